mfp_line_engine: RTL and testbench

- Bresenham line-rasterisation engine driven by the system's memory-mapped line-drawing registers: X0, Y0, X1, Y1, START and RESET in, FINISH out.
- It sits directly downstream of the system top. It consumes the endpoint coordinates and the start strobe, and emits one pixel coordinate per accepted transfer on a valid/ready stream to the framebuffer writer.
- It reports completion back to the CPU on line_finish.

---
 rtl/mfp_line_engine.sv | 94 +++++++++
 tb/tb_mfp_line_engine.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/mfp_line_engine.sv
// mfp_line_engine: Bresenham line rasteriser emitting one pixel per valid/ready handshake
module mfp_line_engine #(
  parameter int COORD_W = 13
) (
  input  logic               HCLK,
  input  logic               HRESETn,
  input  logic [COORD_W-1:0] line_x0,
  input  logic [COORD_W-1:0] line_y0,
  input  logic [COORD_W-1:0] line_x1,
  input  logic [COORD_W-1:0] line_y1,
  input  logic               line_start,
  input  logic               line_reset,
  output logic               line_finish,
  output logic [COORD_W-1:0] pix_x,
  output logic [COORD_W-1:0] pix_y,
  output logic               pix_valid,
  input  logic               pix_ready,
  output logic [COORD_W:0]   pix_count
);
  localparam logic [1:0] IDLE = 2'd0, SETUP = 2'd1, DRAW = 2'd2, DONE = 2'd3;
  localparam logic [COORD_W-1:0] unit = 1;
  localparam logic [COORD_W:0] unit_c = 1;
  logic [1:0] state;
  logic start_q;
  logic [COORD_W-1:0] x0_r, y0_r, x1_r, y1_r, cur_x, cur_y, adx, ady;
  logic signed [COORD_W:0] dx, dy;
  logic signed [COORD_W+1:0] err, err_x, err_y;
  logic signed [COORD_W+2:0] e2, dx_w, dy_w;
  logic sx_neg, sy_neg, start_edge, at_end, step_x, step_y;
  assign start_edge = line_start & ~start_q;
  assign at_end = (cur_x == x1_r) && (cur_y == y1_r);
  assign adx = (x1_r >= x0_r) ? x1_r - x0_r : x0_r - x1_r;
  assign ady = (y1_r >= y0_r) ? y1_r - y0_r : y0_r - y1_r;
  // e2 is 2*err widened by one bit so the doubling can never overflow
  assign e2 = {err, 1'b0};
  assign dx_w = {{2{dx[COORD_W]}}, dx};
  assign dy_w = {{2{dy[COORD_W]}}, dy};
  assign step_x = e2 >= dy_w;
  assign step_y = e2 <= dx_w;
  assign err_x = step_x ? dy_w[COORD_W+1:0] : '0;
  assign err_y = step_y ? dx_w[COORD_W+1:0] : '0;
  assign pix_valid = (state == DRAW);
  assign pix_x = cur_x;
  assign pix_y = cur_y;
  // line FSM: latch endpoints, set up Bresenham terms, step one pixel per accepted handshake
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state <= IDLE;
      start_q <= 1'b0;
      line_finish <= 1'b0;
      pix_count <= '0;
      {x0_r, y0_r, x1_r, y1_r, cur_x, cur_y} <= '0;
      {dx, dy, err, sx_neg, sy_neg} <= '0;
    end else begin
      start_q <= line_start;
      if (line_reset) begin
        state <= IDLE;
        line_finish <= 1'b0;
        pix_count <= '0;
      end else begin
        case (state)
          IDLE: if (start_edge) begin
            {x0_r, y0_r, x1_r, y1_r} <= {line_x0, line_y0, line_x1, line_y1};
            line_finish <= 1'b0;
            pix_count <= '0;
            state <= SETUP;
          end
          SETUP: begin
            dx <= {1'b0, adx};
            dy <= '0 - {1'b0, ady};
            err <= {2'b00, adx} - {2'b00, ady};
            sx_neg <= !(x0_r < x1_r);
            sy_neg <= !(y0_r < y1_r);
            cur_x <= x0_r;
            cur_y <= y0_r;
            state <= DRAW;
          end
          DRAW: if (pix_ready) begin
            pix_count <= pix_count + unit_c;
            if (at_end) begin
              state <= DONE;
              line_finish <= 1'b1;
            end else begin
              err <= err + err_x + err_y;
              if (step_x) cur_x <= sx_neg ? cur_x - unit : cur_x + unit;
              if (step_y) cur_y <= sy_neg ? cur_y - unit : cur_y + unit;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_mfp_line_engine.sv
// tb_mfp_line_engine: directed-vector bench for the Bresenham line engine
module tb_mfp_line_engine;
  logic HCLK = 1'b0;
  logic HRESETn = 1'b0;
  logic [12:0] line_x0 = '0, line_y0 = '0, line_x1 = '0, line_y1 = '0;
  logic line_start = 1'b0, line_reset = 1'b0, pix_ready = 1'b0;
  logic line_finish, pix_valid;
  logic [12:0] pix_x, pix_y;
  logic [13:0] pix_count;
  int n_chk = 0;
  int n_fail = 0;
  int ex[$], ey[$];
  mfp_line_engine #(.COORD_W(13)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .line_x0(line_x0), .line_y0(line_y0), .line_x1(line_x1), .line_y1(line_y1),
    .line_start(line_start), .line_reset(line_reset), .line_finish(line_finish),
    .pix_x(pix_x), .pix_y(pix_y), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_count(pix_count)
  );
  always #5 HCLK = ~HCLK;
  task automatic step();
    @(posedge HCLK);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic start_line(input int x0, input int y0, input int x1, input int y1);
    line_start = 1'b0;
    line_x0 = 13'(x0); line_y0 = 13'(y0); line_x1 = 13'(x1); line_y1 = 13'(y1);
    step();
    line_start = 1'b1;
    step();
    chk("setup_no_valid", 32'(pix_valid), 0);
    step();
  endtask
  task automatic expect_pixels(input string tag);
    for (int i = 0; i < ex.size(); i++) begin
      chk({tag, "_valid"}, 32'(pix_valid), 1);
      chk({tag, "_x"}, 32'(pix_x), 32'(ex[i]));
      chk({tag, "_y"}, 32'(pix_y), 32'(ey[i]));
      step();
    end
    chk({tag, "_finish"}, 32'(line_finish), 1);
    chk({tag, "_done_nv"}, 32'(pix_valid), 0);
    chk({tag, "_count"}, 32'(pix_count), 32'(ex.size()));
  endtask
  initial begin
    #2;
    chk("rst_finish", 32'(line_finish), 0);
    chk("rst_valid", 32'(pix_valid), 0);
    chk("rst_x", 32'(pix_x), 0);
    chk("rst_y", 32'(pix_y), 0);
    chk("rst_count", 32'(pix_count), 0);
    #5 HRESETn = 1'b1;
    step();
    pix_ready = 1'b1;
    start_line(0, 0, 4, 0);
    ex = '{0, 1, 2, 3, 4}; ey = '{0, 0, 0, 0, 0};
    expect_pixels("horiz");
    step();
    chk("horiz_finish_idle", 32'(line_finish), 1);
    start_line(10, 10, 7, 2);
    chk("steep_finish_cleared", 32'(line_finish), 0);
    ex = '{10, 10, 9, 9, 8, 8, 8, 7, 7}; ey = '{10, 9, 8, 7, 6, 5, 4, 3, 2};
    expect_pixels("steep");
    start_line(0, 0, 3, 3);
    for (int i = 0; i < 4; i++) begin
      chk("diag_x", 32'(pix_x), 32'(i));
      chk("diag_y", 32'(pix_y), 32'(i));
      pix_ready = 1'b0;
      step();
      chk("diag_hold_valid", 32'(pix_valid), 1);
      chk("diag_hold_x", 32'(pix_x), 32'(i));
      chk("diag_hold_y", 32'(pix_y), 32'(i));
      chk("diag_hold_count", 32'(pix_count), 32'(i));
      pix_ready = 1'b1;
      step();
    end
    chk("diag_finish", 32'(line_finish), 1);
    chk("diag_count", 32'(pix_count), 4);
    start_line(5, 5, 5, 5);
    ex = '{5}; ey = '{5};
    expect_pixels("degen");
    start_line(0, 0, 100, 0);
    for (int i = 0; i < 10; i++) step();
    chk("abort_pre_x", 32'(pix_x), 10);
    chk("abort_pre_count", 32'(pix_count), 10);
    line_reset = 1'b1;
    step();
    line_reset = 1'b0;
    chk("abort_valid", 32'(pix_valid), 0);
    chk("abort_finish", 32'(line_finish), 0);
    chk("abort_count", 32'(pix_count), 0);
    step();
    step();
    chk("abort_no_retrigger", 32'(pix_valid), 0);
    start_line(8191, 8191, 8190, 8191);
    ex = '{8191, 8190}; ey = '{8191, 8191};
    expect_pixels("corner");
    start_line(0, 0, 20, 0);
    step();
    step();
    chk("hrst_pre_valid", 32'(pix_valid), 1);
    HRESETn = 1'b0;
    #1;
    chk("hrst_valid", 32'(pix_valid), 0);
    chk("hrst_x", 32'(pix_x), 0);
    chk("hrst_count", 32'(pix_count), 0);
    chk("hrst_finish", 32'(line_finish), 0);
    #1;
    line_start = 1'b0;
    HRESETn = 1'b1;
    step();
    step();
    chk("hrst_idle", 32'(pix_valid), 0);
    start_line(0, 0, 5, 0);
    for (int i = 0; i < 6; i++) begin
      chk("ign_x", 32'(pix_x), 32'(i));
      if (i == 2) line_start = 1'b0;
      if (i == 3) begin
        line_start = 1'b1;
        line_x1 = 13'd50;
      end
      step();
    end
    chk("ign_finish", 32'(line_finish), 1);
    chk("ign_count", 32'(pix_count), 6);
    step();
    step();
    chk("ign_no_queue", 32'(pix_valid), 0);
    chk("ign_count_kept", 32'(pix_count), 6);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
